// File: rtl/mc_sequencer.sv
// Multi-cycle RISC-V control sequencer.
// Steps each instruction through fetch, decode, execute, memory and
// write-back phases and drives the datapath enables and mux selects.
// A bounded wait counter guards every memory handshake. An illegal opcode
// or a memory timeout parks the machine in TRAP until reset.
module mc_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       Btaken,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [1:0] ALUop,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Opcodes recognised in DECODE.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The last count at which a missing mem_ready is still tolerated; one more
  // idle cycle means WAIT_LIMIT cycles have been spent waiting.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

  // ALU operand and operation encodings presented to the datapath.
  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_OLDPC  = 2'b01;
  localparam logic [1:0] A_RS1    = 2'b10;
  localparam logic [1:0] B_RS2    = 2'b00;
  localparam logic [1:0] B_IMM    = 2'b01;
  localparam logic [1:0] B_FOUR   = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_CMP  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_UP   = 2'b11;

  // Result and PC source encodings.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;
  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_ALURES  = 2'b10;

  state_t     state_q;
  logic [3:0] wait_cnt;
  logic [6:0] op_q;

  // State register, wait counter and the opcode captured in DECODE.
  // NOTE: every register here uses <= so all of them update from the values
  // that held before the edge; blocking assignments would leak new values
  // into later statements of the same block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
    end else begin
      case (state_q)
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            case (state_q)
              S_FETCH:   state_q <= S_DECODE;
              S_MEMREAD: state_q <= S_MEMWB;
              default:   state_q <= S_FETCH;
            endcase
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state_q  <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_LOAD, OP_STORE:  state_q <= S_MEMADR;
            OP_R:               state_q <= S_EXEC_R;
            OP_I, OP_SYSTEM:    state_q <= S_EXEC_I;
            OP_BRANCH:          state_q <= S_BRANCH;
            OP_JAL:             state_q <= S_JAL;
            OP_JALR:            state_q <= S_JALR;
            OP_LUI, OP_AUIPC:   state_q <= S_UPPER;
            default:            state_q <= S_TRAP;
          endcase
        end
        // Only loads and stores reach MEMADR, so the store opcode alone
        // separates the two paths.
        S_MEMADR:  state_q <= (op_q == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_EXEC_R,
        S_EXEC_I,
        S_UPPER:   state_q <= S_ALUWB;
        S_MEMWB,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR:    state_q <= S_FETCH;
        S_TRAP:    state_q <= S_TRAP;
        // Codes 14 and 15 are not legal states.
        default:   state_q <= S_TRAP;
      endcase
    end
  end

  // Datapath controls decoded from the current state.
  // NOTE: every output gets its default before the case so no path through
  // this block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrc_A   = A_PC;
    ALUSrc_B   = B_RS2;
    ALUop      = ALU_ADD;
    PCSrc      = PC_PLUS4;
    instr_done = 1'b0;
    trap       = 1'b0;
    // Holding reset forces every control quiet, even though the state
    // register already reads FETCH. After release, FETCH drives MemRead
    // before the first edge.
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead  = 1'b1;
          ALUSrc_A = A_PC;
          ALUSrc_B = B_FOUR;
          // IR and PC are committed only in the cycle the fetch completes.
          IRWrite  = mem_ready;
          PCWrite  = mem_ready;
        end
        S_DECODE: begin
          // Precompute PC-relative targets for branches and JAL.
          ALUSrc_A = A_OLDPC;
          ALUSrc_B = B_IMM;
        end
        S_MEMADR: begin
          ALUSrc_A = A_RS1;
          ALUSrc_B = B_IMM;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          ResultSrc  = RES_DATA;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          AdrSrc     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrc_A = A_RS1;
          ALUSrc_B = B_RS2;
          ALUop    = ALU_FUNC;
        end
        S_EXEC_I: begin
          ALUSrc_A = A_RS1;
          ALUSrc_B = B_IMM;
          ALUop    = ALU_FUNC;
        end
        S_UPPER: begin
          ALUSrc_A = A_OLDPC;
          ALUSrc_B = B_IMM;
          ALUop    = ALU_UP;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          ResultSrc  = RES_ALUOUT;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrc_A   = A_RS1;
          ALUSrc_B   = B_RS2;
          ALUop      = ALU_CMP;
          PCSrc      = PC_ALUOUT;
          PCWrite    = Btaken;
          instr_done = 1'b1;
        end
        S_JAL: begin
          PCWrite    = 1'b1;
          PCSrc      = PC_ALUOUT;
          RegWrite   = 1'b1;
          ResultSrc  = RES_PC4;
          instr_done = 1'b1;
        end
        S_JALR: begin
          ALUSrc_A   = A_RS1;
          ALUSrc_B   = B_IMM;
          PCWrite    = 1'b1;
          PCSrc      = PC_ALURES;
          RegWrite   = 1'b1;
          ResultSrc  = RES_PC4;
          instr_done = 1'b1;
        end
        S_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer.
// Each instruction is expanded from its opcode class into an expected
// cycle-by-cycle trace of inputs and outputs. The trace is then replayed
// against the design with a comparison on every cycle.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       Btaken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       IRWrite, PCWrite, RegWrite, MemRead, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrc_A, ALUSrc_B, ALUop, PCSrc;
  logic       instr_done, trap;
  logic [3:0] state;

  mc_sequencer #(.WAIT_LIMIT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .Btaken     (Btaken),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrc_A   (ALUSrc_A),
    .ALUSrc_B   (ALUSrc_B),
    .ALUop      (ALUop),
    .PCSrc      (PCSrc),
    .instr_done (instr_done),
    .trap       (trap),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Packed view of the observable controls.
  wire [11:0] ctrl = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, AdrSrc,
                      instr_done, trap, PCSrc, ResultSrc};

  localparam logic [11:0] C_IR   = 12'h800;
  localparam logic [11:0] C_PCW  = 12'h400;
  localparam logic [11:0] C_RW   = 12'h200;
  localparam logic [11:0] C_MRD  = 12'h100;
  localparam logic [11:0] C_MWR  = 12'h080;
  localparam logic [11:0] C_ADR  = 12'h040;
  localparam logic [11:0] C_DONE = 12'h020;
  localparam logic [11:0] C_TRAP = 12'h010;
  localparam logic [11:0] C_PC01 = 12'h004;
  localparam logic [11:0] C_PC10 = 12'h008;
  localparam logic [11:0] C_RS10 = 12'h002;
  // Fields that are defined in every state, then the ones defined only in some.
  localparam logic [11:0] M_EN   = 12'hFB0;
  localparam logic [11:0] M_ADR  = 12'h040;
  localparam logic [11:0] M_PCS  = 12'h00C;
  localparam logic [11:0] M_RS   = 12'h003;

  typedef enum {K_LOAD, K_STORE, K_ALU_R, K_ALU_I, K_BR, K_JAL, K_JALR,
                K_UP, K_ILL} kind_t;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic        bt;
    logic [3:0]  st;
    logic [11:0] ex;
    logic [11:0] mk;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  logic [6:0] legal [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111, 7'b1110011};

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      7'b0000011:             return K_LOAD;
      7'b0100011:             return K_STORE;
      7'b0110011:             return K_ALU_R;
      7'b0010011, 7'b1110011: return K_ALU_I;
      7'b1100011:             return K_BR;
      7'b1101111:             return K_JAL;
      7'b1100111:             return K_JALR;
      7'b0110111, 7'b0010111: return K_UP;
      default:                return K_ILL;
    endcase
  endfunction

  task automatic add(input logic [3:0] st, input logic mr, input logic bt,
                     input logic [6:0] op, input logic [11:0] ex,
                     input logic [11:0] mk);
    cyc_t c;
    c.op = op; c.mr = mr; c.bt = bt; c.st = st; c.ex = ex; c.mk = mk;
    q.push_back(c);
  endtask

  // TRAP: everything quiet except trap, while mem_ready toggles.
  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++)
      add(4'd13, 1'(i % 2), rb(), rop(), C_TRAP, M_EN);
  endtask

  // Expand one instruction into its expected trace.
  // fw/dw: idle cycles before mem_ready for the fetch/data access;
  // 15 or more means the access never completes.
  task automatic build(input logic [6:0] op, input int fw, input int dw,
                       input logic bt);
    kind_t       k;
    logic [3:0]  st;
    logic [11:0] en;
    k = classify(op);
    for (int i = 0; i < fw && i < 15; i++)
      add(4'd0, 1'b0, rb(), rop(), C_MRD, M_EN | M_ADR);
    if (fw >= 15) begin
      trap_tail(5);
      return;
    end
    add(4'd0, 1'b1, rb(), rop(), C_IR | C_PCW | C_MRD, M_EN | M_ADR | M_PCS);
    add(4'd1, rb(), rb(), op, 12'h000, M_EN);
    case (k)
      K_LOAD, K_STORE: begin
        add(4'd2, rb(), rb(), rop(), 12'h000, M_EN);
        st = (k == K_LOAD) ? 4'd3 : 4'd5;
        en = (k == K_LOAD) ? C_MRD : C_MWR;
        for (int i = 0; i < dw && i < 15; i++)
          add(st, 1'b0, rb(), rop(), en | C_ADR, M_EN | M_ADR);
        if (dw >= 15) trap_tail(5);
        else if (k == K_LOAD) begin
          add(4'd3, 1'b1, rb(), rop(), C_MRD | C_ADR, M_EN | M_ADR);
          add(4'd4, rb(), rb(), rop(), C_RW | C_DONE, M_EN);
        end else begin
          add(4'd5, 1'b1, rb(), rop(), C_MWR | C_ADR | C_DONE, M_EN | M_ADR);
        end
      end
      K_ALU_R, K_ALU_I, K_UP: begin
        st = (k == K_ALU_R) ? 4'd6 : (k == K_ALU_I) ? 4'd7 : 4'd12;
        add(st, rb(), rb(), rop(), 12'h000, M_EN);
        add(4'd8, rb(), rb(), rop(), C_RW | C_DONE, M_EN);
      end
      K_BR:
        add(4'd9, rb(), bt, rop(), (bt ? C_PCW : 12'h000) | C_DONE | C_PC01,
            M_EN | M_PCS);
      K_JAL:
        add(4'd10, rb(), rb(), rop(), C_PCW | C_RW | C_DONE | C_PC01 | C_RS10,
            M_EN | M_PCS | M_RS);
      K_JALR:
        add(4'd11, rb(), rb(), rop(), C_PCW | C_RW | C_DONE | C_PC10 | C_RS10,
            M_EN | M_PCS | M_RS);
      default: trap_tail(20);
    endcase
  endtask

  // Replay the trace; entered and left just after a falling edge.
  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode    = c.op;
      mem_ready = c.mr;
      Btaken    = c.bt;
      #1;
      check($sformatf("state@%0d", cyc_no), 32'(state), 32'(c.st));
      check($sformatf("ctrl@%0d", cyc_no), 32'(ctrl & c.mk), 32'(c.ex & c.mk));
      cyc_no++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_quiet(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_ctrl"}, 32'(ctrl), 32'd0);
    check({tag, "_sel"}, 32'({ALUSrc_A, ALUSrc_B, ALUop}), 32'd0);
  endtask

  // Short reset pulse that never spans a rising edge; then one idle fetch cycle.
  task automatic reset_pulse(input string tag);
    mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_reset_quiet(tag);
    #1 reset_n = 1'b1;
    #1;
    check({tag, "_rel_state"}, 32'(state), 32'd0);
    check({tag, "_rel_ctrl"}, 32'(ctrl & (M_EN | M_ADR)), 32'(C_MRD));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_fetch"}, 32'(state), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, before and after clock edges while held.
    #3 check_reset_quiet("reset_pre_edge");
    @(negedge clk);
    #1 check_reset_quiet("reset_held");
    reset_n = 1'b1;

    // R-type with no waits, then load with a 3-cycle data wait.
    build(7'b0110011, 0, 0, 1'b0); play();
    build(7'b0000011, 0, 3, 1'b0); play();
    // Branch not taken, then taken.
    build(7'b1100011, 0, 0, 1'b0); play();
    build(7'b1100011, 0, 0, 1'b1); play();
    // One of each remaining class.
    build(7'b0100011, 2, 2, 1'b0); play();
    build(7'b1101111, 1, 0, 1'b0); play();
    build(7'b1100111, 0, 0, 1'b0); play();
    build(7'b0110111, 0, 0, 1'b0); play();
    build(7'b0010111, 0, 0, 1'b0); play();
    build(7'b1110011, 0, 0, 1'b0); play();
    build(7'b0010011, 1, 0, 1'b0); play();
    // Longest tolerated waits.
    build(7'b0110011, 14, 0, 1'b0); play();
    build(7'b0000011, 0, 14, 1'b0); play();
    build(7'b0100011, 0, 14, 1'b0); play();

    // Random instruction mix.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      int fw, dw;
      op = legal[$urandom_range(0, 9)];
      fw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4));
      dw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4));
      build(op, fw, dw, rb());
      play();
    end

    // Illegal opcode parks in TRAP for 20 cycles, then reset recovers.
    build(7'b0000000, 0, 0, 1'b0); play();
    reset_pulse("illegal_rst");
    build(7'b0110011, 0, 0, 1'b0); play();

    // Fetch timeout after 15 idle cycles, then reset without a clock edge.
    build(7'b0110011, 15, 0, 1'b0); play();
    reset_pulse("fetch_to_rst");
    // Store data timeout.
    build(7'b0100011, 0, 15, 1'b0); play();
    reset_pulse("store_to_rst");
    build(7'b0000011, 1, 1, 1'b0); play();

    // Reset while a store waits: MemWrite drops at once, no retirement.
    build(7'b0100011, 0, 3, 1'b0);
    void'(q.pop_back());
    play();
    #1;
    check("store_wait_state", 32'(state), 32'd5);
    check("store_wait_mwr", 32'(MemWrite), 32'd1);
    reset_pulse("store_abort");
    build(7'b0100011, 1, 1, 1'b0); play();
    build(7'b1100111, 0, 0, 1'b0); play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
